// File: rtl/palindrome_win_det.sv
// Streaming palindrome detector over the last WIN accepted bits of a serial stream.
// Optional saturating hit counter compiled in with `define PALIN_HIT_CNT_EN.
module palindrome_win_det #(
    parameter int WIN   = 3,
    parameter int HIT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic             x_i,
    input  logic             clear_i,
    output logic             palindrome_o,
    output logic             filled_o,
`ifdef PALIN_HIT_CNT_EN
    output logic [HIT_W-1:0] hit_cnt_o,
`endif
    output logic [1:0]       fill_state_o
);

    // Handshake: x_i is consumed on a rising edge where valid_i=1 and clear_i=0;
    // there is no backpressure, the detector accepts every offered bit.

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_FULL    = 2'd2
    } fill_state_t;

    localparam int                FILL_W   = $clog2(WIN);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(WIN - 1);
    localparam logic [FILL_W-1:0] FILL_ONE = FILL_W'(1);

    generate
        if (WIN < 2 || WIN > 64 || HIT_W < 1) begin : g_param_check
            $error("palindrome_win_det: WIN must be 2..64 and HIT_W >= 1");
        end
    endgenerate

    fill_state_t       state_q, state_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [WIN-2:0]    hist_q, hist_d, hist_shift;
    logic [WIN-1:0]    win_w;
    logic [WIN/2-1:0]  pair_eq;
    logic              match;

    generate
        if (WIN == 2) begin : g_hist_one
            assign hist_shift = x_i;
        end else begin : g_hist_many
            assign hist_shift = {hist_q[WIN-3:0], x_i};
        end
    endgenerate

    // win_w[0] is the oldest bit in the window, win_w[WIN-1] the incoming one.
    assign win_w[WIN-1] = x_i;
    generate
        for (genvar k = 0; k < WIN - 1; k++) begin : g_win
            assign win_w[k] = hist_q[WIN-2-k];
        end
        for (genvar k = 0; k < WIN / 2; k++) begin : g_pair
            assign pair_eq[k] = (win_w[k] == win_w[WIN-1-k]);
        end
    endgenerate

    assign match        = &pair_eq;
    assign filled_o     = (fill_q == FILL_MAX);
    assign palindrome_o = valid_i & filled_o & ~clear_i & match;
    assign fill_state_o = state_q;

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        hist_d  = hist_q;
        if (clear_i) begin
            state_d = ST_EMPTY;
            fill_d  = '0;
            hist_d  = '0;
        end else if (valid_i) begin
            hist_d = hist_shift;
            case (state_q)
                ST_EMPTY: begin
                    fill_d  = FILL_ONE;
                    state_d = (FILL_ONE == FILL_MAX) ? ST_FULL : ST_FILLING;
                end
                ST_FILLING: begin
                    fill_d  = fill_q + FILL_ONE;
                    state_d = ((fill_q + FILL_ONE) == FILL_MAX) ? ST_FULL : ST_FILLING;
                end
                ST_FULL: begin
                    fill_d  = FILL_MAX;
                    state_d = ST_FULL;
                end
                default: begin
                    fill_d  = '0;
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
            fill_q  <= '0;
            hist_q  <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            hist_q  <= hist_d;
        end
    end

`ifdef PALIN_HIT_CNT_EN
    logic [HIT_W-1:0] cnt_q, cnt_d;

    // Saturates rather than wraps so a long run of hits never reads as few.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (palindrome_o && (cnt_q != {HIT_W{1'b1}})) begin
            cnt_d = cnt_q + HIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_palindrome_win_det.sv
// Bench for palindrome_win_det: four instances (WIN=3,4,5,2) checked against a
// list-based window model; hit counter checks compile in with PALIN_HIT_CNT_EN.
module tb_palindrome_win_det;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] rst_a;
    logic [3:0] valid_a;
    logic [3:0] x_a;
    logic [3:0] clr_a;
    logic [3:0] pal_a;
    logic [3:0] fill_a;
    logic [1:0] st_a [4];
`ifdef PALIN_HIT_CNT_EN
    logic [1:0] cnt_a [4];
`endif

    generate
        for (genvar g = 0; g < 4; g++) begin : g_dut
            localparam int GW = (g == 0) ? 3 : (g == 1) ? 4 : (g == 2) ? 5 : 2;
            palindrome_win_det #(.WIN(GW), .HIT_W(2)) u_dut (
                .clk          (clk),
                .reset        (rst_a[g]),
                .valid_i      (valid_a[g]),
                .x_i          (x_a[g]),
                .clear_i      (clr_a[g]),
                .palindrome_o (pal_a[g]),
                .filled_o     (fill_a[g]),
`ifdef PALIN_HIT_CNT_EN
                .hit_cnt_o    (cnt_a[g]),
`endif
                .fill_state_o (st_a[g])
            );
        end
    endgenerate

    int n_checks = 0;
    int n_fail   = 0;

    // Model: accepted bits since the last flush, most recent at index 0.
    bit mbits [4][64];
    int mlen  [4];
    int mcnt  [4];

    bit       exp_pal, exp_fill, obs_pal, obs_fill;
    int       exp_cnt, exp_st;
    logic [1:0] obs_cnt, obs_st;

    function automatic int win_of(input int i);
        case (i)
            0: return 3;
            1: return 4;
            2: return 5;
            default: return 2;
        endcase
    endfunction

    task automatic model_flush(input int i);
        mlen[i] = 0;
        mcnt[i] = 0;
        for (int j = 0; j < 64; j++) mbits[i][j] = 1'b0;
    endtask

    // One clock of stimulus on instance i; predicts, samples at negedge, then advances.
    task automatic step(input int i, input bit v, input bit xb, input bit c, input bit r);
        int win;
        bit w[$];
        bit is_pal;
        valid_a[i] = v;
        x_a[i]     = xb;
        clr_a[i]   = c;
        rst_a[i]   = r;
        win = win_of(i);
        w.delete();
        for (int j = win - 2; j >= 0; j--) w.push_back(mbits[i][j]);
        w.push_back(xb);
        is_pal = 1'b1;
        for (int k = 0; k < win; k++) if (w[k] != w[win-1-k]) is_pal = 1'b0;
        exp_fill = (mlen[i] >= win - 1);
        exp_pal  = v && !c && exp_fill && is_pal;
        exp_st   = (mlen[i] == 0) ? 0 : ((mlen[i] < win - 1) ? 1 : 2);
        exp_cnt  = mcnt[i];
        @(negedge clk);
        obs_pal  = pal_a[i];
        obs_fill = fill_a[i];
        obs_st   = st_a[i];
`ifdef PALIN_HIT_CNT_EN
        obs_cnt  = cnt_a[i];
`else
        obs_cnt  = 2'd0;
`endif
        @(posedge clk);
        if (!r || c) begin
            model_flush(i);
        end else if (v) begin
            for (int j = 63; j > 0; j--) mbits[i][j] = mbits[i][j-1];
            mbits[i][0] = xb;
            if (mlen[i] < 63) mlen[i]++;
            if (exp_pal && mcnt[i] < 3) mcnt[i]++;
        end
        #1;
        valid_a[i] = 1'b0;
        clr_a[i]   = 1'b0;
        rst_a[i]   = 1'b1;
    endtask

    task automatic test_reset();
        rst_a = 4'h0;
        @(posedge clk);
        #1;
        rst_a = 4'hF;
        for (int i = 0; i < 4; i++) model_flush(i);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (fill_a[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_filled inst%0d: got %b want 0", i, fill_a[i]);
            end
            n_checks++;
            if (st_a[i] !== 2'd0) begin
                n_fail++;
                $display("FAIL reset_state inst%0d: got %0d want 0", i, st_a[i]);
            end
`ifdef PALIN_HIT_CNT_EN
            n_checks++;
            if (cnt_a[i] !== 2'd0) begin
                n_fail++;
                $display("FAIL reset_hit_cnt inst%0d: got %0d want 0", i, cnt_a[i]);
            end
`endif
        end
        @(posedge clk);
        #1;
        step(0, 1'b1, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (obs_pal !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_hit: got %b want 0", obs_pal);
        end
    endtask

    task automatic test_first_hit();
        bit [2:0] seq;
        seq = 3'b101;
        step(0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(0, 1'b1, seq[2-k], 1'b0, 1'b1);
            n_checks++;
            if (obs_pal !== (k == 2)) begin
                n_fail++;
                $display("FAIL first_hit bit%0d: got %b want %b", k + 1, obs_pal, (k == 2));
            end
            n_checks++;
            if (obs_fill !== (k == 2)) begin
                n_fail++;
                $display("FAIL first_filled bit%0d: got %b want %b", k + 1, obs_fill, (k == 2));
            end
        end
    endtask

    task automatic test_even_window();
        bit [9:0] seq;
        bit [9:0] hits;
        seq  = 10'b1001100110;   // first accepted bit is the MSB
        hits = 10'b0001010101;   // windows 1001, 0110, 1001, 0110 end at bits 4,6,8,10
        step(1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step(1, 1'b1, seq[9-k], 1'b0, 1'b1);
            n_checks++;
            if (obs_pal !== hits[9-k] || obs_pal !== exp_pal) begin
                n_fail++;
                $display("FAIL even_window bit%0d: got %b want %b", k + 1, obs_pal, hits[9-k]);
            end
        end
    endtask

    task automatic test_valid_gaps();
        step(0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(0, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(0, 1'b0, k[0], 1'b0, 1'b1);
            n_checks++;
            if (obs_pal !== 1'b0) begin
                n_fail++;
                $display("FAIL gap_idle%0d: got %b want 0", k, obs_pal);
            end
        end
        step(0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(0, 1'b0, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (obs_pal !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_idle_full: got %b want 0", obs_pal);
        end
        step(0, 1'b1, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (obs_pal !== 1'b1) begin
            n_fail++;
            $display("FAIL gap_final_hit: got %b want 1", obs_pal);
        end
    endtask

    task automatic test_flush();
        bit [2:0] seq;
        seq = 3'b101;
        step(0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(0, 1'b1, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if (obs_pal !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_cycle: got %b want 0", obs_pal);
        end
        for (int k = 0; k < 3; k++) begin
            step(0, 1'b1, seq[2-k], 1'b0, 1'b1);
            n_checks++;
            if (obs_pal !== (k == 2)) begin
                n_fail++;
                $display("FAIL flush_refill bit%0d: got %b want %b", k + 1, obs_pal, (k == 2));
            end
        end
    endtask

    task automatic test_reset_midstream();
        bit [4:0] seq;
        seq = 5'b11011;
        step(2, 1'b0, 1'b0, 1'b0, 1'b0);
        step(2, 1'b1, 1'b1, 1'b0, 1'b1);
        step(2, 1'b1, 1'b1, 1'b0, 1'b1);
        step(2, 1'b1, 1'b0, 1'b0, 1'b1);
        step(2, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(2, 1'b1, seq[4-k], 1'b0, 1'b1);
            n_checks++;
            if (obs_pal !== (k == 4)) begin
                n_fail++;
                $display("FAIL midrst_hit bit%0d: got %b want %b", k + 1, obs_pal, (k == 4));
            end
            n_checks++;
            if (obs_fill !== (k == 4)) begin
                n_fail++;
                $display("FAIL midrst_filled bit%0d: got %b want %b", k + 1, obs_fill, (k == 4));
            end
        end
    endtask

`ifdef PALIN_HIT_CNT_EN
    task automatic test_hit_counter();
        int want [5];
        want = '{1, 2, 3, 3, 3};
        step(3, 1'b0, 1'b0, 1'b0, 1'b0);
        step(3, 1'b1, 1'b1, 1'b0, 1'b1);
        step(3, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step(3, (k < 4), 1'b1, 1'b0, 1'b1);
            n_checks++;
            if (obs_cnt !== 2'(want[k])) begin
                n_fail++;
                $display("FAIL hit_cnt step%0d: got %0d want %0d", k, obs_cnt, want[k]);
            end
        end
        step(3, 1'b1, 1'b1, 1'b1, 1'b1);
        step(3, 1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (obs_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL hit_cnt_clear: got %0d want 0", obs_cnt);
        end
    endtask
`endif

    task automatic test_random();
        bit v, xb, c, r;
        for (int i = 0; i < 4; i++) begin
            for (int n = 0; n < 300; n++) begin
                v  = ($urandom_range(0, 3) != 0);
                xb = 1'($urandom_range(0, 1));
                c  = ($urandom_range(0, 23) == 0);
                r  = ($urandom_range(0, 39) != 0);
                step(i, v, xb, c, r);
                n_checks++;
                if (obs_pal !== exp_pal || obs_fill !== exp_fill || obs_st !== 2'(exp_st)) begin
                    n_fail++;
                    $display("FAIL random inst%0d n%0d: pal/fill/st got %b/%b/%0d want %b/%b/%0d",
                             i, n, obs_pal, obs_fill, obs_st, exp_pal, exp_fill, exp_st);
                end
`ifdef PALIN_HIT_CNT_EN
                n_checks++;
                if (obs_cnt !== 2'(exp_cnt)) begin
                    n_fail++;
                    $display("FAIL random_cnt inst%0d n%0d: got %0d want %0d", i, n, obs_cnt, exp_cnt);
                end
`endif
            end
        end
    endtask

    initial begin
        rst_a   = 4'h0;
        valid_a = 4'h0;
        x_a     = 4'h0;
        clr_a   = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_first_hit();
        test_even_window();
        test_valid_gaps();
        test_flush();
        test_reset_midstream();
`ifdef PALIN_HIT_CNT_EN
        test_hit_counter();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
